// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the masked single-port SRAM wrapper:
//   - init_state_t : clear-sequencer FSM states (ST_INIT, ST_IDLE)
//   - calc_addr_w  : address width from depth, never below 1 bit
//   - seg_parity   : even-parity bit of one mask segment (zero-padded input)
//   - read_lat_ok / mask_gran_ok / depth_ok : parameter legality predicates,
//     evaluated by the top at elaboration time
// -----------------------------------------------------------------------------
package sram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } init_state_t;

   // Widest segment the parity helper accepts; segments are zero-extended to it.
   localparam int PAR_MAX_GRAN = 1024;

   function automatic int calc_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic seg_parity(input logic [PAR_MAX_GRAN-1:0] seg);
      return ^seg;
   endfunction

   function automatic bit read_lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic bit mask_gran_ok(input int width, input int gran);
      return (gran > 0) && (gran <= PAR_MAX_GRAN) && (width >= gran) && ((width % gran) == 0);
   endfunction

   function automatic bit depth_ok(input int depth);
      return depth >= 2;
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// -----------------------------------------------------------------------------
// sram_init_seq
// Post-reset clear sequencer. After reset it walks every address once
// (exactly DEPTH cycles in ST_INIT), then parks in ST_IDLE until the next reset.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   init_active  : 1 while the clear walk is writing init_addr
//   init_addr    : address being cleared this cycle
//   RW0_ready    : 1 once the array is cleared (ST_IDLE)
//   state        : current FSM state, exposed for observation
// -----------------------------------------------------------------------------
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = calc_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_active,
   output logic [ADDR_W-1:0] init_addr,
   output logic              RW0_ready,
   output init_state_t       state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   init_state_t       state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: the last clear write happens in the cycle cnt==LAST_ADDR,
   // and the move to ST_IDLE takes effect on that same edge.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_INIT: begin
            if (cnt == LAST_ADDR) begin
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // Outputs
   always_comb begin
      init_active = (state == ST_INIT);
      init_addr   = cnt;
      RW0_ready   = (state == ST_IDLE);
   end

endmodule

// File: rtl/sram_sp_masked.sv
// -----------------------------------------------------------------------------
// sram_sp_masked
// Parametrised single-port synchronous SRAM with per-segment write mask,
// read latency of 1 or 2 cycles, read-valid strobe and a post-reset clear.
// Optional feature macro: SRAM_PARITY_EN (one even-parity bit per segment,
// checked on read and reported on RW0_perr alongside RW0_rvalid).
// Ports:
//   RW0_clk, RW0_reset : clock, asynchronous active-high reset
//   RW0_addr           : word address
//   RW0_en, RW0_wmode  : request strobe; wmode 1 = write, 0 = read
//   RW0_wmask          : per-segment write enable
//   RW0_wdata          : write data
//   RW0_ready          : array cleared, requests accepted
//   RW0_rdata          : read data, holds last delivered value
//   RW0_rvalid         : one-cycle strobe for new RW0_rdata
//   RW0_perr           : parity mismatch on the delivered word
// -----------------------------------------------------------------------------
module sram_sp_masked
   import sram_pkg::*;
#(
   parameter int  DEPTH     = 64,
   parameter int  WIDTH     = 50,
   parameter int  MASK_GRAN = 50,
   parameter int  READ_LAT  = 1,
   localparam int ADDR_W    = calc_addr_w(DEPTH),
   localparam int MASK_SEG  = WIDTH / MASK_GRAN
) (
   input  logic                RW0_clk,
   input  logic                RW0_reset,
   input  logic [ADDR_W-1:0]   RW0_addr,
   input  logic                RW0_en,
   input  logic                RW0_wmode,
   input  logic [MASK_SEG-1:0] RW0_wmask,
   input  logic [WIDTH-1:0]    RW0_wdata,
   output logic                RW0_ready,
   output logic [WIDTH-1:0]    RW0_rdata,
   output logic                RW0_rvalid,
   output logic                RW0_perr
);

   if (!read_lat_ok(READ_LAT)) begin : g_chk_lat
      $error("sram_sp_masked: READ_LAT must be 1 or 2");
   end
   if (!mask_gran_ok(WIDTH, MASK_GRAN)) begin : g_chk_gran
      $error("sram_sp_masked: WIDTH must be a positive multiple of MASK_GRAN");
   end
   if (!depth_ok(DEPTH)) begin : g_chk_depth
      $error("sram_sp_masked: DEPTH must be at least 2");
   end

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------- clear FSM
   logic              init_active;
   logic [ADDR_W-1:0] init_addr;
   init_state_t       init_state;

   sram_init_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_seq (
      .clk         (RW0_clk),
      .rst         (RW0_reset),
      .init_active (init_active),
      .init_addr   (init_addr),
      .RW0_ready   (RW0_ready),
      .state       (init_state)
   );

   // ---------------------------------------------------------- request decode
   logic accept;
   logic addr_ok;
   logic wr_req;
   logic rd_req;

   // Requests during the clear walk are dropped entirely.
   assign accept  = RW0_en && (init_state == ST_IDLE);
   // Only reachable as false for non-power-of-2 depths.
   assign addr_ok = ({1'b0, RW0_addr} < DEPTH_V);
   assign wr_req  = accept && RW0_wmode && addr_ok;
   assign rd_req  = accept && !RW0_wmode;

   // ----------------------------------------------------------------- storage
   logic [WIDTH-1:0] mem_data [DEPTH];
   logic [WIDTH-1:0] rd_word;
   logic             rd_perr;

   always_ff @(posedge RW0_clk) begin
      if (init_active) begin
         mem_data[init_addr] <= '0;
      end else if (wr_req) begin
         for (int i = 0; i < MASK_SEG; i++) begin
            if (RW0_wmask[i]) begin
               mem_data[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Out-of-range reads deliver zero rather than whatever the array returns.
   assign rd_word = addr_ok ? mem_data[RW0_addr] : '0;

`ifdef SRAM_PARITY_EN
   logic [MASK_SEG-1:0] mem_par [DEPTH];
   logic [MASK_SEG-1:0] wpar;
   logic [MASK_SEG-1:0] rpar_calc;
   logic [MASK_SEG-1:0] rpar_stored;

   always_comb begin
      wpar      = '0;
      rpar_calc = '0;
      for (int i = 0; i < MASK_SEG; i++) begin
         wpar[i]      = seg_parity(PAR_MAX_GRAN'(RW0_wdata[i*MASK_GRAN +: MASK_GRAN]));
         rpar_calc[i] = seg_parity(PAR_MAX_GRAN'(rd_word[i*MASK_GRAN +: MASK_GRAN]));
      end
   end

   // Parity of an all-zero segment is 0, so the clear walk stores zeros.
   always_ff @(posedge RW0_clk) begin
      if (init_active) begin
         mem_par[init_addr] <= '0;
      end else if (wr_req) begin
         for (int i = 0; i < MASK_SEG; i++) begin
            if (RW0_wmask[i]) begin
               mem_par[RW0_addr][i] <= wpar[i];
            end
         end
      end
   end

   assign rpar_stored = addr_ok ? mem_par[RW0_addr] : '0;
   assign rd_perr     = |(rpar_calc ^ rpar_stored);
`else
   assign rd_perr = 1'b0;
`endif

   // ------------------------------------------------------------ read pipeline
   // Stage 1 captures the array word on the request edge, so a write in the
   // previous cycle is already visible (write-first across cycles).
   logic             s1_valid;
   logic             s1_perr;
   logic [WIDTH-1:0] s1_data;

   always_ff @(posedge RW0_clk or posedge RW0_reset) begin
      if (RW0_reset) begin
         s1_valid <= 1'b0;
         s1_perr  <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_req;
         if (rd_req) begin
            s1_data <= rd_word;
            s1_perr <= rd_perr;
         end
      end
   end

   logic out_perr;

   if (READ_LAT == 2) begin : g_lat2
      logic             s2_valid;
      logic             s2_perr;
      logic [WIDTH-1:0] s2_data;

      always_ff @(posedge RW0_clk or posedge RW0_reset) begin
         if (RW0_reset) begin
            s2_valid <= 1'b0;
            s2_perr  <= 1'b0;
            s2_data  <= '0;
         end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_data;
               s2_perr <= s1_perr;
            end
         end
      end

      assign RW0_rvalid = s2_valid;
      assign RW0_rdata  = s2_data;
      assign out_perr   = s2_perr;
   end else begin : g_lat1
      assign RW0_rvalid = s1_valid;
      assign RW0_rdata  = s1_data;
      assign out_perr   = s1_perr;
   end

   // Error flag is only meaningful alongside the valid strobe.
   assign RW0_perr = RW0_rvalid && out_perr;

endmodule
